// File: rtl/axis_master_splitter_if.sv
// AXI-Stream master-side bundle used by axis_master_splitter.
// master: drives tvalid/tlast/tkeep/tdata, samples tready. slave: the reverse.
interface axis_master_splitter_if #(
    parameter int unsigned T_DATA_WIDTH = 8,
    parameter int unsigned M_KEEP_WIDTH = 4
) ();
    logic                                 tvalid;
    logic                                 tready;
    logic                                 tlast;
    logic [M_KEEP_WIDTH-1:0]              tkeep;
    logic [M_KEEP_WIDTH*T_DATA_WIDTH-1:0] tdata;

    modport master (
        output tvalid,
        output tlast,
        output tkeep,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tlast,
        input  tkeep,
        input  tdata,
        output tready
    );
endinterface

// File: rtl/axis_master_splitter.sv
// Output stage of the width resizer. Pops M_KEEP_WIDTH-lane entries from the
// output buffer and drives an AXI-Stream master, splitting an entry at every
// kept lane flagged last so each beat carries at most one packet boundary.
// Optional: define AXIS_MASTER_STATS_EN to add beat/packet counters.
module axis_master_splitter #(
    parameter int unsigned T_DATA_WIDTH = 8,
    parameter int unsigned M_KEEP_WIDTH = 4
`ifdef AXIS_MASTER_STATS_EN
    ,
    parameter int unsigned CNT_WIDTH = 16
`endif
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     e_valid_i,
    output logic                                     e_ready_o,
    input  logic [(2+T_DATA_WIDTH)*M_KEEP_WIDTH-1:0] e_entry_i,
    axis_master_splitter_if.master                   m_if
`ifdef AXIS_MASTER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]                     pkt_cnt_o,
    output logic [CNT_WIDTH-1:0]                     beat_cnt_o
`endif
);

    localparam int unsigned LANE_W  = 2 + T_DATA_WIDTH;
    localparam int unsigned ENTRY_W = LANE_W * M_KEEP_WIDTH;
    localparam int unsigned DATA_W  = M_KEEP_WIDTH * T_DATA_WIDTH;

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e                  state_q, state_d;
    logic [ENTRY_W-1:0]      entry_q, entry_d;
    logic [M_KEEP_WIDTH-1:0] rem_q, rem_d;

    logic                    m_valid_q, m_valid_d;
    logic                    m_last_q, m_last_d;
    logic [M_KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
    logic [DATA_W-1:0]       m_data_q, m_data_d;

    logic [M_KEEP_WIDTH-1:0] lane_keep, lane_last, lane_valid, new_keep;
    logic [M_KEEP_WIDTH-1:0] seg_keep, consumed, rem_next;
    logic [DATA_W-1:0]       seg_data;
    logic                    seg_last, seg_final, seg_avail, load, e_ready;

    // Unpack per-lane keep/last flags of the held and the incoming entry.
    always_comb begin
        lane_keep = '0;
        lane_last = '0;
        new_keep  = '0;
        for (int unsigned i = 0; i < M_KEEP_WIDTH; i++) begin
            lane_keep[i] = entry_q[i*LANE_W];
            lane_last[i] = entry_q[i*LANE_W+1];
            new_keep[i]  = e_entry_i[i*LANE_W];
        end
    end

    // A lane still counts only while unsent; last on an unkept lane is ignored.
    assign lane_valid = lane_keep & rem_q;

    // Next segment: remaining lanes up to and including the first kept last lane.
    always_comb begin
        seg_keep = '0;
        seg_data = '0;
        seg_last = 1'b0;
        consumed = '0;
        for (int unsigned i = 0; i < M_KEEP_WIDTH; i++) begin
            if (!seg_last) begin
                consumed[i] = 1'b1;
                if (lane_valid[i]) begin
                    seg_keep[i]                        = 1'b1;
                    seg_data[i*T_DATA_WIDTH +: T_DATA_WIDTH] =
                        entry_q[i*LANE_W+2 +: T_DATA_WIDTH];
                    if (lane_last[i]) begin
                        seg_last = 1'b1;
                    end
                end
            end
        end
    end

    assign rem_next  = rem_q & ~consumed;
    assign seg_final = ~|(rem_next & lane_keep);
    // In HOLD at least one valid lane always remains, else the FSM left HOLD.
    assign seg_avail = (state_q == StHold) && (|lane_valid);
    assign load      = seg_avail && (!m_valid_q || m_if.tready);

    // FSM next state and pop strobe; a new entry is taken on the same edge the
    // final segment of the held one moves to the output register.
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        rem_d   = rem_q;
        e_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                e_ready = 1'b1;
            end
            StHold: begin
                if (load) begin
                    if (seg_final) begin
                        state_d = StIdle;
                        e_ready = 1'b1;
                    end else begin
                        rem_d = rem_next;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (e_valid_i && e_ready) begin
            entry_d = e_entry_i;
            rem_d   = '1;
            // Entries with no kept lanes are dropped without producing a beat.
            state_d = (|new_keep) ? StHold : StIdle;
        end
    end

    // Output register: load a segment when the slot is free or being drained;
    // otherwise hold everything stable.
    always_comb begin
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_keep_d  = m_keep_q;
        m_data_d  = m_data_q;
        if (load) begin
            m_valid_d = 1'b1;
            m_last_d  = seg_last;
            m_keep_d  = seg_keep;
            m_data_d  = seg_data;
        end else if (m_if.tready) begin
            m_valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            entry_q   <= '0;
            rem_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_keep_q  <= '0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            entry_q   <= entry_d;
            rem_q     <= rem_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_keep_q  <= m_keep_d;
            m_data_q  <= m_data_d;
        end
    end

    assign e_ready_o   = e_ready;
    assign m_if.tvalid = m_valid_q;
    assign m_if.tlast  = m_last_q;
    assign m_if.tkeep  = m_keep_q;
    assign m_if.tdata  = m_data_q;

`ifdef AXIS_MASTER_STATS_EN
    logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

    // Count completed handshakes; counters wrap naturally.
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        beat_cnt_d = beat_cnt_q;
        if (m_valid_q && m_if.tready) begin
            beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
            if (m_last_q) begin
                pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign pkt_cnt_o  = pkt_cnt_q;
    assign beat_cnt_o = beat_cnt_q;
`endif

endmodule

// File: tb/tb_axis_master_splitter.sv
// Self-checking bench for axis_master_splitter: expected beats are queued by a
// small lane model when an entry is offered and compared by a monitor branch.
module tb_axis_master_splitter;
    localparam int unsigned TDW = 8;
    localparam int unsigned KW  = 4;
    localparam int unsigned LW  = 2 + TDW;
    localparam int unsigned EW  = LW * KW;

    typedef struct packed {
        logic [KW-1:0]     keep;
        logic              last;
        logic [KW*TDW-1:0] data;
    } beat_t;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic          e_valid = 1'b0;
    logic          e_ready;
    logic [EW-1:0] e_entry = '0;
`ifdef AXIS_MASTER_STATS_EN
    logic [15:0]   pkt_cnt;
    logic [15:0]   beat_cnt;
`endif

    axis_master_splitter_if #(.T_DATA_WIDTH(TDW), .M_KEEP_WIDTH(KW)) m_if ();

    axis_master_splitter #(
        .T_DATA_WIDTH(TDW),
        .M_KEEP_WIDTH(KW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .e_valid_i (e_valid),
        .e_ready_o (e_ready),
        .e_entry_i (e_entry),
        .m_if      (m_if)
`ifdef AXIS_MASTER_STATS_EN
        ,
        .pkt_cnt_o (pkt_cnt),
        .beat_cnt_o(beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    int    checks   = 0;
    int    errors   = 0;
    bit    tests_done = 1'b0;
    bit    rand_on  = 1'b0;

    function automatic logic [EW-1:0] mk_entry(input logic [KW-1:0] keep,
                                               input logic [KW-1:0] last,
                                               input logic [KW*TDW-1:0] data);
        logic [EW-1:0] e;
        e = '0;
        for (int i = 0; i < KW; i++) begin
            e[i*LW]            = keep[i];
            e[i*LW+1]          = last[i];
            e[i*LW+2 +: TDW]   = data[i*TDW +: TDW];
        end
        return e;
    endfunction

    // Reference: walk lanes low to high, close a beat at each kept last lane.
    task automatic model_push(input logic [KW-1:0] keep, input logic [KW-1:0] last,
                              input logic [KW*TDW-1:0] data);
        beat_t b;
        b = '0;
        for (int i = 0; i < KW; i++) begin
            if (keep[i]) begin
                b.keep[i]             = 1'b1;
                b.data[i*TDW +: TDW]  = data[i*TDW +: TDW];
                if (last[i]) begin
                    b.last = 1'b1;
                    exp_q.push_back(b);
                    b = '0;
                end
            end
        end
        if (b.keep != '0) exp_q.push_back(b);
    endtask

    task automatic scoreboard_monitor();
        beat_t got, want, prev;
        bit    stalled;
        stalled = 1'b0;
        prev    = '0;
        while (!tests_done) begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
                continue;
            end
            got = {m_if.tkeep, m_if.tlast, m_if.tdata};
            if (stalled) begin
                checks++;
                if (m_if.tvalid !== 1'b1 || got !== prev) begin
                    errors++;
                    $display("FAIL stall_stable got v=%b %h required v=1 %h",
                             m_if.tvalid, got, prev);
                end
            end
            if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected got keep=%b last=%b data=%h required none",
                             got.keep, got.last, got.data);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL beat got keep=%b last=%b data=%h required keep=%b last=%b data=%h",
                                 got.keep, got.last, got.data, want.keep, want.last, want.data);
                    end
                end
            end
            stalled = (m_if.tvalid === 1'b1) && (m_if.tready !== 1'b1);
            prev    = got;
        end
    endtask

    // Offer one entry and return 1 ns after the edge that pops it.
    task automatic send_entry(input logic [KW-1:0] keep, input logic [KW-1:0] last,
                              input logic [KW*TDW-1:0] data);
        bit popped;
        popped = 1'b0;
        model_push(keep, last, data);
        e_entry = mk_entry(keep, last, data);
        e_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (e_ready === 1'b1) begin
                popped = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        e_valid = 1'b0;
        checks++;
        if (!popped) begin
            errors++;
            $display("FAIL pop_timeout got e_ready=0 required 1");
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 300; c++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d beats pending required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #20;
        checks++;
        if ({m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b l=%b k=%b d=%h required all 0",
                     m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (e_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_e_ready got %b required 1", e_ready);
        end
        checks++;
        if (m_if.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b required 0", m_if.tvalid);
        end
`ifdef AXIS_MASTER_STATS_EN
        checks++;
        if (pkt_cnt !== 16'd0 || beat_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters got %0d/%0d required 0/0", beat_cnt, pkt_cnt);
        end
`endif
    endtask

    task automatic test_single();
        send_entry(4'b1111, 4'b0000, 32'hDDCCBBAA);
        @(negedge clk);
        checks++;
        if (m_if.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency got valid=%b required 0", m_if.tvalid);
        end
        @(negedge clk);
        checks++;
        if ({m_if.tvalid, m_if.tkeep, m_if.tlast, m_if.tdata} !== {1'b1, 4'b1111, 1'b0, 32'hDDCCBBAA}) begin
            errors++;
            $display("FAIL single_beat got v=%b k=%b l=%b d=%h required v=1 k=1111 l=0 d=ddccbbaa",
                     m_if.tvalid, m_if.tkeep, m_if.tlast, m_if.tdata);
        end
        wait_drain();
    endtask

    task automatic test_split();
        send_entry(4'b1111, 4'b0010, 32'h44332211);
        @(negedge clk);
        checks++;
        if (e_ready !== 1'b0) begin
            errors++;
            $display("FAIL split_e_ready_low got %b required 0", e_ready);
        end
        @(negedge clk);
        checks++;
        if ({m_if.tvalid, m_if.tkeep, m_if.tlast, e_ready} !== {1'b1, 4'b0011, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL split_beat0 got v=%b k=%b l=%b rdy=%b required v=1 k=0011 l=1 rdy=1",
                     m_if.tvalid, m_if.tkeep, m_if.tlast, e_ready);
        end
        @(negedge clk);
        checks++;
        if ({m_if.tvalid, m_if.tkeep, m_if.tlast} !== {1'b1, 4'b1100, 1'b0}) begin
            errors++;
            $display("FAIL split_beat1 got v=%b k=%b l=%b required v=1 k=1100 l=0",
                     m_if.tvalid, m_if.tkeep, m_if.tlast);
        end
        wait_drain();
    endtask

    task automatic test_multi_last();
        logic [KW-1:0] exp_keep [3];
        logic          exp_last [3];
        logic          exp_rdy  [3];
        exp_keep = '{4'b0001, 4'b0110, 4'b1000};
        exp_last = '{1'b1, 1'b1, 1'b0};
        exp_rdy  = '{1'b0, 1'b1, 1'b1};
        send_entry(4'b1111, 4'b0101, 32'h0D0C0B0A);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({m_if.tvalid, m_if.tkeep, m_if.tlast, e_ready} !==
                {1'b1, exp_keep[k], exp_last[k], exp_rdy[k]}) begin
                errors++;
                $display("FAIL multi_beat%0d got v=%b k=%b l=%b rdy=%b required v=1 k=%b l=%b rdy=%b",
                         k, m_if.tvalid, m_if.tkeep, m_if.tlast, e_ready,
                         exp_keep[k], exp_last[k], exp_rdy[k]);
            end
        end
        @(negedge clk);
        checks++;
        if (m_if.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL multi_end_valid got %b required 0", m_if.tvalid);
        end
        wait_drain();
    endtask

    task automatic test_zero_keep();
        send_entry(4'b0000, 4'b1111, 32'h99887766);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (m_if.tvalid !== 1'b0 || e_ready !== 1'b1) begin
                errors++;
                $display("FAIL zero_keep got valid=%b e_ready=%b required 0/1", m_if.tvalid, e_ready);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [36:0] snap;
        bit          popped;
        m_if.tready = 1'b0;
        send_entry(4'b1111, 4'b0101, 32'h5A6B7C8D);
        @(negedge clk);
        @(negedge clk);
        snap = {m_if.tvalid, m_if.tkeep, m_if.tdata};
        checks++;
        if (m_if.tvalid !== 1'b1 || m_if.tkeep !== 4'b0001) begin
            errors++;
            $display("FAIL bp_first got v=%b k=%b required v=1 k=0001", m_if.tvalid, m_if.tkeep);
        end
        model_push(4'b1111, 4'b1000, 32'hF1E2D3C4);
        e_entry = mk_entry(4'b1111, 4'b1000, 32'hF1E2D3C4);
        e_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({m_if.tvalid, m_if.tkeep, m_if.tdata} !== snap || e_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold got %h rdy=%b required %h rdy=0",
                         {m_if.tvalid, m_if.tkeep, m_if.tdata}, e_ready, snap);
            end
        end
        @(posedge clk);
        #1;
        m_if.tready = 1'b1;
        popped = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (e_ready === 1'b1) begin
                popped = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        e_valid = 1'b0;
        checks++;
        if (!popped) begin
            errors++;
            $display("FAIL bp_pop_timeout got e_ready=0 required 1");
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [KW*TDW-1:0] d;
        int                waits;
        waits = 0;
        for (int k = 0; k < 6; k++) begin
            d = $urandom;
            model_push(4'b1111, 4'b0000, d);
            e_entry = mk_entry(4'b1111, 4'b0000, d);
            e_valid = 1'b1;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                waits++;
                if (e_ready === 1'b1) break;
            end
            @(posedge clk);
            #1;
        end
        e_valid = 1'b0;
        checks++;
        if (waits != 6) begin
            errors++;
            $display("FAIL b2b_throughput got %0d cycles required 6", waits);
        end
        wait_drain();
    endtask

    task automatic test_random();
        rand_on = 1'b1;
        fork
            begin
                for (int k = 0; k < 25; k++) begin
                    send_entry(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    m_if.tready = 1'($urandom_range(0, 1));
                end
                m_if.tready = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_reset_mid();
        send_entry(4'b1111, 4'b0101, 32'h13243546);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got v=%b l=%b k=%b d=%h required all 0",
                     m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata);
        end
        exp_q.delete();
`ifdef AXIS_MASTER_STATS_EN
        checks++;
        if (pkt_cnt !== 16'd0 || beat_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_counters got %0d/%0d required 0/0", beat_cnt, pkt_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (m_if.tvalid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_lost got valid=%b required 0", m_if.tvalid);
            end
        end
        @(posedge clk);
        #1;
        send_entry(4'b1111, 4'b0101, 32'hCAFEF00D);
        wait_drain();
`ifdef AXIS_MASTER_STATS_EN
        checks++;
        if (beat_cnt !== 16'd3 || pkt_cnt !== 16'd2) begin
            errors++;
            $display("FAIL stats_count got beats=%0d pkts=%0d required 3/2", beat_cnt, pkt_cnt);
        end
`endif
    endtask

    initial begin
        m_if.tready = 1'b1;
        fork
            scoreboard_monitor();
            begin
                test_reset();
                test_single();
                test_split();
                test_multi_last();
                test_zero_keep();
                test_backpressure();
                test_back_to_back();
                test_random();
                test_reset_mid();
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL leftover got %0d beats required 0", exp_q.size());
                end
                tests_done = 1'b1;
            end
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule
